// File: rtl/bernoulli_sampler_pkg.sv
// Shared types and defaults for the Bernoulli sampling stage of the RBM datapath.
package bernoulli_sampler_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_UNITS = 16;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    function automatic int count_width(input int units);
        return $clog2(units + 1);
    endfunction

endpackage

// File: rtl/bernoulli_sampler_if.sv
// Probability input stream and sample-vector output stream of the sampler.
// Valid/ready: a beat transfers on a rising edge where valid and ready are both 1;
// the source holds its payload stable while valid=1 and ready=0.
interface bernoulli_sampler_if
    import bernoulli_sampler_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int UNITS = DEFAULT_UNITS
);
    localparam int CW = count_width(UNITS);

    logic             prob_valid;
    logic             prob_ready;
    logic [WIDTH-1:0] prob;
    logic             sample_valid;
    logic             sample_ready;
    logic [UNITS-1:0] sample_vec;
    logic [CW-1:0]    ones_count;

    // master: the surrounding datapath (probability source and vector sink).
    modport master (
        output prob_valid, prob, sample_ready,
        input  prob_ready, sample_valid, sample_vec, ones_count
    );

    // slave: the sampler itself.
    modport slave (
        input  prob_valid, prob, sample_ready,
        output prob_ready, sample_valid, sample_vec, ones_count
    );

endinterface

// File: rtl/bernoulli_sampler.sv
// Turns a stream of UNITS probabilities into one vector of Bernoulli sample bits
// (bit = rnd < prob) plus its population count, handed off with valid/ready.
module bernoulli_sampler
    import bernoulli_sampler_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int UNITS = DEFAULT_UNITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         rnd,
    input  logic                     clear,
    bernoulli_sampler_if.slave       bus,
    output state_t                   state_dbg,
    output logic [$clog2(UNITS)-1:0] idx_dbg
);
    localparam int IW = $clog2(UNITS);
    localparam int CW = count_width(UNITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(UNITS - 1);

    state_t           state_q;
    state_t           state_d;
    logic [IW-1:0]    idx_q;
    logic [UNITS-1:0] vec_q;
    logic [CW-1:0]    cnt_q;
    logic             accept;
    logic             sample_bit;

    assign accept     = (state_q == ST_COLLECT) && bus.prob_valid && !clear;
    assign sample_bit = (rnd < bus.prob);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_COLLECT;
        end else begin
            case (state_q)
                ST_COLLECT: if (accept && idx_q == LAST_IDX) state_d = ST_HOLD;
                ST_HOLD:    if (bus.sample_ready)           state_d = ST_COLLECT;
                default:                                    state_d = ST_COLLECT;
            endcase
        end
    end

    // Comparator result, index, vector and ones counter all advance together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            vec_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            idx_q <= '0;
            vec_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            vec_q[idx_q] <= sample_bit;
            cnt_q        <= cnt_q + CW'(sample_bit);
            idx_q        <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end else if (state_q == ST_HOLD && bus.sample_ready) begin
            vec_q <= '0;
            cnt_q <= '0;
        end
    end

    assign bus.prob_ready   = (state_q == ST_COLLECT);
    assign bus.sample_valid = (state_q == ST_HOLD);
    assign bus.sample_vec   = vec_q;
    assign bus.ones_count   = cnt_q;
    assign state_dbg        = state_q;
    assign idx_dbg          = idx_q;

endmodule

// File: tb/tb_bernoulli_sampler.sv
// Directed bench for bernoulli_sampler with UNITS=4, WIDTH=8 and a bench-driven rnd.
module tb_bernoulli_sampler;
    import bernoulli_sampler_pkg::*;

    localparam int WIDTH = 8;
    localparam int UNITS = 4;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] rnd;
    logic             clear;
    state_t           state_dbg;
    logic [1:0]       idx_dbg;

    int checks = 0;
    int errors = 0;

    bernoulli_sampler_if #(.WIDTH(WIDTH), .UNITS(UNITS)) bus ();

    bernoulli_sampler #(.WIDTH(WIDTH), .UNITS(UNITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .rnd       (rnd),
        .clear     (clear),
        .bus       (bus.slave),
        .state_dbg (state_dbg),
        .idx_dbg   (idx_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [7:0] p, input logic [7:0] r);
        bus.prob       = p;
        rnd            = r;
        bus.prob_valid = 1'b1;
        step();
        bus.prob_valid = 1'b0;
    endtask

    task automatic release_vec();
        bus.sample_ready = 1'b1;
        step();
        bus.sample_ready = 1'b0;
    endtask

    task automatic feed_extremes();
        accept(8'h00, 8'h80);
        accept(8'hFF, 8'h80);
        accept(8'h80, 8'h80);
        accept(8'h81, 8'h80);
    endtask

    initial begin
        reset            = 1'b1;
        clear            = 1'b0;
        rnd              = '0;
        bus.prob         = '0;
        bus.prob_valid   = 1'b0;
        bus.sample_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        chk("rst_prob_ready", 32'(bus.prob_ready), 32'd1);
        chk("rst_sample_valid", 32'(bus.sample_valid), 32'd0);
        chk("rst_vec", 32'(bus.sample_vec), 32'd0);
        chk("rst_count", 32'(bus.ones_count), 32'd0);
        chk("rst_idx", 32'(idx_dbg), 32'd0);

        // extremes: rnd=80, probs 00,FF,80,81 -> 1010, count 2
        accept(8'h00, 8'h80);
        accept(8'hFF, 8'h80);
        chk("ext_partial_vec", 32'(bus.sample_vec), 32'h2);
        chk("ext_partial_idx", 32'(idx_dbg), 32'd2);
        accept(8'h80, 8'h80);
        chk("ext_not_valid_yet", 32'(bus.sample_valid), 32'd0);
        accept(8'h81, 8'h80);
        chk("ext_valid", 32'(bus.sample_valid), 32'd1);
        chk("ext_vec", 32'(bus.sample_vec), 32'hA);
        chk("ext_count", 32'(bus.ones_count), 32'd2);
        chk("ext_idx_wrap", 32'(idx_dbg), 32'd0);

        // backpressure with a beat offered during HOLD
        bus.prob       = 8'hFF;
        rnd            = 8'h00;
        bus.prob_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_vec", 32'(bus.sample_vec), 32'hA);
            chk("bp_prob_ready", 32'(bus.prob_ready), 32'd0);
        end
        bus.prob_valid = 1'b0;
        chk("bp_count", 32'(bus.ones_count), 32'd2);
        release_vec();
        chk("rel_vec", 32'(bus.sample_vec), 32'd0);
        chk("rel_count", 32'(bus.ones_count), 32'd0);
        chk("rel_prob_ready", 32'(bus.prob_ready), 32'd1);
        chk("rel_sample_valid", 32'(bus.sample_valid), 32'd0);

        // bubbles of 3 idle cycles between beats
        for (int b = 0; b < 4; b++) begin
            case (b)
                0: accept(8'h00, 8'h80);
                1: accept(8'hFF, 8'h80);
                2: accept(8'h80, 8'h80);
                default: accept(8'h81, 8'h80);
            endcase
            if (b < 3) begin
                for (int g = 0; g < 3; g++) begin
                    rnd = 8'($urandom_range(0, 255));
                    step();
                    chk("bub_idx_held", 32'(idx_dbg), 32'(b + 1));
                end
            end
        end
        chk("bub_vec", 32'(bus.sample_vec), 32'hA);
        chk("bub_count", 32'(bus.ones_count), 32'd2);
        release_vec();

        // mixed rnd values: 40<40 false, FF<FF false
        accept(8'h40, 8'h3F);
        accept(8'h40, 8'h40);
        accept(8'hC0, 8'hFF);
        accept(8'h01, 8'h00);
        chk("mix_vec", 32'(bus.sample_vec), 32'h9);
        chk("mix_count", 32'(bus.ones_count), 32'd2);
        release_vec();
        accept(8'hFF, 8'hFF);
        accept(8'hFF, 8'h00);
        accept(8'hFF, 8'hFE);
        accept(8'hFF, 8'h7F);
        chk("ff_vec", 32'(bus.sample_vec), 32'hE);
        chk("ff_count", 32'(bus.ones_count), 32'd3);
        release_vec();
        for (int k = 0; k < 4; k++) accept(8'hFF, 8'h10);
        chk("full_vec", 32'(bus.sample_vec), 32'hF);
        chk("full_count", 32'(bus.ones_count), 32'd4);
        release_vec();

        // clear after 2 accepts, beat presented with clear is dropped
        accept(8'hFF, 8'h00);
        accept(8'hFF, 8'h00);
        chk("clr_pre_vec", 32'(bus.sample_vec), 32'h3);
        clear          = 1'b1;
        bus.prob       = 8'hFF;
        rnd            = 8'h00;
        bus.prob_valid = 1'b1;
        step();
        clear          = 1'b0;
        bus.prob_valid = 1'b0;
        chk("clr_vec", 32'(bus.sample_vec), 32'd0);
        chk("clr_count", 32'(bus.ones_count), 32'd0);
        chk("clr_idx", 32'(idx_dbg), 32'd0);
        chk("clr_state", 32'(state_dbg), 32'(ST_COLLECT));
        feed_extremes();
        chk("clr_fresh_vec", 32'(bus.sample_vec), 32'hA);
        chk("clr_fresh_valid", 32'(bus.sample_valid), 32'd1);

        // clear in HOLD without sample_ready
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clrh_state", 32'(state_dbg), 32'(ST_COLLECT));
        chk("clrh_vec", 32'(bus.sample_vec), 32'd0);

        // clear in HOLD together with sample_ready
        feed_extremes();
        chk("clrh2_valid_pre", 32'(bus.sample_valid), 32'd1);
        clear            = 1'b1;
        bus.sample_ready = 1'b1;
        step();
        clear            = 1'b0;
        bus.sample_ready = 1'b0;
        chk("clrh2_state", 32'(state_dbg), 32'(ST_COLLECT));
        chk("clrh2_vec", 32'(bus.sample_vec), 32'd0);
        chk("clrh2_count", 32'(bus.ones_count), 32'd0);

        // async reset between clock edges mid-vector
        accept(8'hFF, 8'h00);
        accept(8'hFF, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_vec", 32'(bus.sample_vec), 32'd0);
        chk("arst_count", 32'(bus.ones_count), 32'd0);
        chk("arst_idx", 32'(idx_dbg), 32'd0);
        chk("arst_prob_ready", 32'(bus.prob_ready), 32'd1);
        chk("arst_sample_valid", 32'(bus.sample_valid), 32'd0);
        #1;
        reset = 1'b0;
        feed_extremes();
        chk("arst_fresh_vec", 32'(bus.sample_vec), 32'hA);
        chk("arst_fresh_count", 32'(bus.ones_count), 32'd2);
        chk("arst_fresh_valid", 32'(bus.sample_valid), 32'd1);

        // ready tied high: HOLD lasts one cycle
        bus.sample_ready = 1'b1;
        step();
        chk("tied_collect", 32'(state_dbg), 32'(ST_COLLECT));
        bus.sample_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
